// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    // ALU operand source selects
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // Stall lengths when no forwarding path exists (register file is not write-through)
    localparam logic [1:0] STALL_EX  = 2'd3;
    localparam logic [1:0] STALL_MEM = 2'd2;
    localparam logic [1:0] STALL_WB  = 2'd1;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline-stage hazard inputs and controller enables/selects/counters.
// Latency: n/a (wiring only).
// Backpressure: n/a; the controller produces the pipeline's stall enables itself.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] rsAddrDec_i;
    logic [REG_ADDR_W-1:0] rtAddrDec_i;
    logic                  usesRt_i;
    logic [REG_ADDR_W-1:0] writeAddrRegEx_i;
    logic                  regWriteEx_i;
    logic                  memToReadEx_i;
    logic [REG_ADDR_W-1:0] writeAddrRegMem_i;
    logic                  regWriteMem_i;
    logic [REG_ADDR_W-1:0] writeAddrRegWb_i;
    logic                  regWriteWb_i;
    logic                  branchTaken_i;
    logic                  pcWrite_o;
    logic                  fdWrite_o;
    logic                  fdFlush_o;
    logic                  deFlush_o;
    logic                  emFlush_o;
    logic [1:0]            forwardA_o;
    logic [1:0]            forwardB_o;
    logic [CNT_W-1:0]      stallCount_o;
    logic [CNT_W-1:0]      flushCount_o;

    // Pipeline datapath side: supplies stage addresses, consumes enables
    modport master (
        output rsAddrDec_i, rtAddrDec_i, usesRt_i,
        output writeAddrRegEx_i, regWriteEx_i, memToReadEx_i,
        output writeAddrRegMem_i, regWriteMem_i,
        output writeAddrRegWb_i, regWriteWb_i, branchTaken_i,
        input  pcWrite_o, fdWrite_o, fdFlush_o, deFlush_o, emFlush_o,
        input  forwardA_o, forwardB_o, stallCount_o, flushCount_o
    );

    // Hazard controller side
    modport slave (
        input  rsAddrDec_i, rtAddrDec_i, usesRt_i,
        input  writeAddrRegEx_i, regWriteEx_i, memToReadEx_i,
        input  writeAddrRegMem_i, regWriteMem_i,
        input  writeAddrRegWb_i, regWriteWb_i, branchTaken_i,
        output pcWrite_o, fdWrite_o, fdFlush_o, deFlush_o, emFlush_o,
        output forwardA_o, forwardB_o, stallCount_o, flushCount_o
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd.sv
// Forwarding unit: registers EX-stage source addresses and selects MEM/WB bypass per operand.
// Latency: selects are combinational from the registered EX sources (1 cycle after DE load).
// Backpressure: none; the source register clears whenever DE loads a bubble.
`ifdef PIPELINE_HAZARD_FORWARDING_EN
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [REG_ADDR_W-1:0] rs_dec,
    input  logic [REG_ADDR_W-1:0] rt_dec,
    input  logic                  de_flush,
    input  logic [REG_ADDR_W-1:0] mem_addr,
    input  logic                  mem_we,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic                  wb_we,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b
);

    logic [REG_ADDR_W-1:0] rs_ex;
    logic [REG_ADDR_W-1:0] rt_ex;

    function automatic logic [1:0] pick(input logic [REG_ADDR_W-1:0] src,
                                        input logic [REG_ADDR_W-1:0] m_addr, input logic m_we,
                                        input logic [REG_ADDR_W-1:0] w_addr, input logic w_we);
        if (m_we && (m_addr != '0) && (m_addr == src))      return FWD_MEM;
        else if (w_we && (w_addr != '0) && (w_addr == src)) return FWD_WB;
        else                                                 return FWD_REG;
    endfunction

    // EX source addresses follow the DE buffer; a bubble carries $0 so it never matches
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rs_ex <= '0;
            rt_ex <= '0;
        end else if (de_flush) begin
            rs_ex <= '0;
            rt_ex <= '0;
        end else begin
            rs_ex <= rs_dec;
            rt_ex <= rt_dec;
        end
    end

    // Per-operand bypass select, youngest producer (MEM) first
    always_comb begin
        forward_a = pick(rs_ex, mem_addr, mem_we, wb_addr, wb_we);
        forward_b = pick(rt_ex, mem_addr, mem_we, wb_addr, wb_we);
    end

endmodule
`endif

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: RAW hazard stalls, taken-branch flushes, stall/flush perf counters.
// Latency: enables are combinational in the detecting cycle; multi-cycle stalls run from a down-counter.
// Backpressure: holds PC/FD and bubbles DE while stalled; PIPELINE_HAZARD_FORWARDING_EN adds bypass (load-use stall only).
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int REG_ADDR_W = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    pipeline_hazard_ctrl_if.slave hz
);

    state_t           state;
    state_t           state_n;
    logic [1:0]       stall_left;
    logic [1:0]       stall_left_n;
    logic [1:0]       stall_len;
    logic             pc_write;
    logic             fd_write;
    logic             fd_flush;
    logic             de_flush;
    logic             em_flush;
    logic             stall_cyc;
    logic             flush_cyc;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // True when a producer writing 'addr' feeds a source the ID instruction actually reads
    function automatic logic src_hit(input logic [REG_ADDR_W-1:0] addr, input logic we,
                                     input logic [REG_ADDR_W-1:0] rs, input logic [REG_ADDR_W-1:0] rt,
                                     input logic uses_rt);
        return we && (addr != '0) && ((addr == rs) || (uses_rt && (addr == rt)));
    endfunction

`ifdef PIPELINE_HAZARD_FORWARDING_EN
    // With bypass only a load in EX cannot be forwarded in time
    always_comb begin
        stall_len = 2'd0;
        if (hz.memToReadEx_i &&
            src_hit(hz.writeAddrRegEx_i, hz.regWriteEx_i, hz.rsAddrDec_i, hz.rtAddrDec_i, hz.usesRt_i))
            stall_len = 2'd1;
    end

    hazard_forward_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .rs_dec    (hz.rsAddrDec_i),
        .rt_dec    (hz.rtAddrDec_i),
        .de_flush  (de_flush),
        .mem_addr  (hz.writeAddrRegMem_i),
        .mem_we    (hz.regWriteMem_i),
        .wb_addr   (hz.writeAddrRegWb_i),
        .wb_we     (hz.regWriteWb_i),
        .forward_a (hz.forwardA_o),
        .forward_b (hz.forwardB_o)
    );
`else
    logic unused_mem_to_read;
    assign unused_mem_to_read = hz.memToReadEx_i;

    // Without bypass the consumer waits until the producer has retired; oldest wait wins
    always_comb begin
        stall_len = 2'd0;
        if (src_hit(hz.writeAddrRegEx_i, hz.regWriteEx_i, hz.rsAddrDec_i, hz.rtAddrDec_i, hz.usesRt_i))
            stall_len = STALL_EX;
        else if (src_hit(hz.writeAddrRegMem_i, hz.regWriteMem_i, hz.rsAddrDec_i, hz.rtAddrDec_i, hz.usesRt_i))
            stall_len = STALL_MEM;
        else if (src_hit(hz.writeAddrRegWb_i, hz.regWriteWb_i, hz.rsAddrDec_i, hz.rtAddrDec_i, hz.usesRt_i))
            stall_len = STALL_WB;
    end

    assign hz.forwardA_o = FWD_REG;
    assign hz.forwardB_o = FWD_REG;
`endif

    // State and remaining-stall register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= INIT;
            stall_left <= 2'd0;
        end else begin
            state      <= state_n;
            stall_left <= stall_left_n;
        end
    end

    // Next state and pipeline enables; a taken branch overrides any stall
    always_comb begin
        state_n      = state;
        stall_left_n = stall_left;
        pc_write     = 1'b0;
        fd_write     = 1'b0;
        fd_flush     = 1'b1;
        de_flush     = 1'b1;
        em_flush     = 1'b1;
        stall_cyc    = 1'b0;
        flush_cyc    = 1'b0;
        case (state)
            INIT: begin
                state_n = RUN;
            end
            RUN, STALL: begin
                if (hz.branchTaken_i) begin
                    pc_write     = 1'b1;
                    fd_write     = 1'b1;
                    flush_cyc    = 1'b1;
                    state_n      = RUN;
                    stall_left_n = 2'd0;
                end else if (state == STALL) begin
                    fd_flush     = 1'b0;
                    em_flush     = 1'b0;
                    stall_cyc    = 1'b1;
                    stall_left_n = stall_left - 2'd1;
                    if (stall_left == 2'd1)
                        state_n = RUN;
                end else if (stall_len != 2'd0) begin
                    fd_flush  = 1'b0;
                    em_flush  = 1'b0;
                    stall_cyc = 1'b1;
                    if (stall_len > 2'd1) begin
                        stall_left_n = stall_len - 2'd1;
                        state_n      = STALL;
                    end
                end else begin
                    pc_write = 1'b1;
                    fd_write = 1'b1;
                    fd_flush = 1'b0;
                    de_flush = 1'b0;
                    em_flush = 1'b0;
                end
            end
            default: begin
                state_n      = INIT;
                stall_left_n = 2'd0;
            end
        endcase
    end

    // Saturating performance counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_cyc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_cyc && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign hz.pcWrite_o    = pc_write;
    assign hz.fdWrite_o    = fd_write;
    assign hz.fdFlush_o    = fd_flush;
    assign hz.deFlush_o    = de_flush;
    assign hz.emFlush_o    = em_flush;
    assign hz.stallCount_o = stall_cnt;
    assign hz.flushCount_o = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench for pipeline_hazard_ctrl against a cycle-level behavioural model.
// Latency: one stimulus vector per clock, outputs sampled just after the falling edge.
// Backpressure: a second narrow-counter instance is held in permanent stall to exercise saturation.
module tb_pipeline_hazard_ctrl;

    localparam int AW      = 5;
    localparam int CW      = 16;
    localparam int CW_SAT  = 4;

    typedef struct {
        logic          rst;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic          ut;
        logic [AW-1:0] exa;
        logic          exw;
        logic          exl;
        logic [AW-1:0] mema;
        logic          memw;
        logic [AW-1:0] wba;
        logic          wbw;
        logic          br;
    } stim_t;

    logic clk;
    logic rst_n;

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(AW), .CNT_W(CW))     hz();
    pipeline_hazard_ctrl_if #(.REG_ADDR_W(AW), .CNT_W(CW_SAT)) hz_sat();

    pipeline_hazard_ctrl #(.CNT_W(CW), .REG_ADDR_W(AW)) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .hz     (hz)
    );

    pipeline_hazard_ctrl #(.CNT_W(CW_SAT), .REG_ADDR_W(AW)) u_sat (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .hz     (hz_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: cycles-since-reset flag, stall cycles still owed, event counts
    bit        m_init  = 1'b1;
    int        m_owed  = 0;
    int        m_stall = 0;
    int        m_flush = 0;
    int        m_sat   = 0;
    logic [AW-1:0] m_ex_rs = '0;
    logic [AW-1:0] m_ex_rt = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int sat_to(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic bit reads(input stim_t s, input logic [AW-1:0] a, input logic we);
        return we && (a != 0) && (a == s.rs || (s.ut && a == s.rt));
    endfunction

    // Cycles of stall the ID instruction needs before it may proceed
    function automatic int needed(input stim_t s);
`ifdef PIPELINE_HAZARD_FORWARDING_EN
        return (s.exl && reads(s, s.exa, s.exw)) ? 1 : 0;
`else
        if (reads(s, s.exa, s.exw))   return 3;
        if (reads(s, s.mema, s.memw)) return 2;
        if (reads(s, s.wba, s.wbw))   return 1;
        return 0;
`endif
    endfunction

    function automatic logic [1:0] fwd_sel(input stim_t s, input logic [AW-1:0] src);
`ifdef PIPELINE_HAZARD_FORWARDING_EN
        if (s.memw && s.mema != 0 && s.mema == src) return 2'b10;
        if (s.wbw && s.wba != 0 && s.wba == src)     return 2'b01;
`endif
        return 2'b00;
    endfunction

    // Apply one cycle of stimulus, compare all outputs with the model, then advance the model
    task automatic step(input stim_t s);
        logic [4:0] ctl; // {pcWrite, fdWrite, fdFlush, deFlush, emFlush}
        logic [1:0] fa, fb;
        int n;
        @(negedge clk);
        rst_n                = s.rst;
        hz.rsAddrDec_i       = s.rs;
        hz.rtAddrDec_i       = s.rt;
        hz.usesRt_i          = s.ut;
        hz.writeAddrRegEx_i  = s.exa;
        hz.regWriteEx_i      = s.exw;
        hz.memToReadEx_i     = s.exl;
        hz.writeAddrRegMem_i = s.mema;
        hz.regWriteMem_i     = s.memw;
        hz.writeAddrRegWb_i  = s.wba;
        hz.regWriteWb_i      = s.wbw;
        hz.branchTaken_i     = s.br;
        #1;
        if (!s.rst) begin
            m_init = 1'b1; m_owed = 0; m_stall = 0; m_flush = 0; m_sat = 0;
            m_ex_rs = '0; m_ex_rt = '0;
        end
        fa = fwd_sel(s, m_ex_rs);
        fb = fwd_sel(s, m_ex_rt);
        check("stall_cnt", 32'(hz.stallCount_o), 32'(sat_to(m_stall, CW)));
        check("flush_cnt", 32'(hz.flushCount_o), 32'(sat_to(m_flush, CW)));
        check("sat_cnt", 32'(hz_sat.stallCount_o), 32'(sat_to(m_sat, CW_SAT)));
        check("fwd_a", 32'(hz.forwardA_o), 32'(fa));
        check("fwd_b", 32'(hz.forwardB_o), 32'(fb));
        if (!s.rst || m_init) begin
            ctl = 5'b00111;
            if (s.rst) m_init = 1'b0;
        end else begin
            m_sat++;
            if (s.br) begin
                ctl = 5'b11111; m_owed = 0; m_flush++;
            end else if (m_owed > 0) begin
                ctl = 5'b00010; m_owed--; m_stall++;
            end else begin
                n = needed(s);
                if (n > 0) begin
                    ctl = 5'b00010; m_owed = n - 1; m_stall++;
                end else begin
                    ctl = 5'b11000;
                end
            end
        end
        check("ctl", 32'({hz.pcWrite_o, hz.fdWrite_o, hz.fdFlush_o, hz.deFlush_o, hz.emFlush_o}), 32'(ctl));
        if (ctl[1]) begin
            m_ex_rs = '0; m_ex_rt = '0;
        end else begin
            m_ex_rs = s.rs; m_ex_rt = s.rt;
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{rst: 1'b1, rs: 5'd1, rt: 5'd2, ut: 1'b1, exa: 5'd9, exw: 1'b0, exl: 1'b0,
              mema: 5'd10, memw: 1'b0, wba: 5'd11, wbw: 1'b0, br: 1'b0};
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.rst  = ($urandom_range(0, 199) != 0);
        s.rs   = 5'($urandom_range(0, 3));
        s.rt   = 5'($urandom_range(0, 3));
        s.ut   = 1'($urandom);
        s.exa  = 5'($urandom_range(0, 3));
        s.exw  = 1'($urandom);
        s.exl  = 1'($urandom);
        s.mema = 5'($urandom_range(0, 3));
        s.memw = 1'($urandom);
        s.wba  = 5'($urandom_range(0, 3));
        s.wbw  = 1'($urandom);
        s.br   = ($urandom_range(0, 7) == 0);
        return s;
    endfunction

    initial begin
        stim_t s;
        // The saturation instance sees a load hazard in EX forever: every RUN cycle stalls
        hz_sat.rsAddrDec_i       = 5'd5;
        hz_sat.rtAddrDec_i       = 5'd0;
        hz_sat.usesRt_i          = 1'b0;
        hz_sat.writeAddrRegEx_i  = 5'd5;
        hz_sat.regWriteEx_i      = 1'b1;
        hz_sat.memToReadEx_i     = 1'b1;
        hz_sat.writeAddrRegMem_i = 5'd0;
        hz_sat.regWriteMem_i     = 1'b0;
        hz_sat.writeAddrRegWb_i  = 5'd0;
        hz_sat.regWriteWb_i      = 1'b0;
        hz_sat.branchTaken_i     = 1'b0;
        rst_n = 1'b0;

        // Reset, INIT cycle (a branch here is ignored), then idle RUN
        s = idle(); s.rst = 1'b0; step(s); step(s);
        s = idle(); s.br = 1'b1; step(s);
        s = idle(); step(s);

        // EX writes $3, ID reads rs=3
        s = idle(); s.rs = 5'd3; s.exa = 5'd3; s.exw = 1'b1;
        repeat (3) step(s);
        s = idle(); step(s);
`ifndef PIPELINE_HAZARD_FORWARDING_EN
        check("ex_stall_total", 32'(hz.stallCount_o), 32'd3);
`endif

        // Producer to $0 never stalls
        s = idle(); s.rs = 5'd0; s.exa = 5'd0; s.exw = 1'b1; s.exl = 1'b1;
        repeat (2) step(s);

        // Fresh reset, then a branch resolving in the second stall cycle
        s = idle(); s.rst = 1'b0; step(s);
        s = idle(); step(s);
        s = idle(); s.rs = 5'd3; s.exa = 5'd3; s.exw = 1'b1; s.exl = 1'b1; step(s);
        s.br = 1'b1; step(s);
        s = idle(); step(s);
        check("br_flush_cnt", 32'(hz.flushCount_o), 32'd1);
        check("br_stall_cnt", 32'(hz.stallCount_o), 32'd1);

        // Reset asserted while a 3-cycle stall is in progress
        s = idle(); s.rs = 5'd3; s.exa = 5'd3; s.exw = 1'b1; step(s);
        s.rst = 1'b0; step(s);
        s = idle(); step(s); step(s);

        // Load-use with rt
        s = idle(); s.rt = 5'd4; s.exa = 5'd4; s.exw = 1'b1; s.exl = 1'b1; step(s);
        s = idle(); s.rt = 5'd4; s.mema = 5'd4; s.memw = 1'b1; step(s);
        s = idle(); s.wba = 5'd4; s.wbw = 1'b1; step(s);

        repeat (3000) step(rnd());

        // Long uninterrupted run so the narrow counter sits at its ceiling
        repeat (25) step(idle());
        check("sat_hold", 32'(hz_sat.stallCount_o), 32'd15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
